// File: rtl/maze_path_reader.sv
// Raster-scans the solved maze after the solver finishes. Every visited cell (code 2)
// is streamed out as a coordinate, and the number of visited cells is reported.
module maze_path_reader #(
  parameter int maze_width = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [maze_width-1:0] row,
  output logic [maze_width-1:0] col,
  output logic                  maze_oe,
  input  logic [1:0]            cell_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [maze_width-1:0] out_row,
  output logic [maze_width-1:0] out_col,
  output logic [2*maze_width:0] path_len,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] cell_visited = 2'd2;

  typedef enum logic [2:0] {
    st_idle,
    st_read,
    st_check,
    st_emit,
    st_finish
  } state_t;

  state_t state;
  logic   last_cell;
  logic   advance;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    last_cell = 1'b0;
    advance   = 1'b0;
    last_cell = (&row) && (&col);
    case (state)
      st_check: advance = (cell_in != cell_visited);
      st_emit:  advance = out_ready;
      default:  advance = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= st_idle;
      row       <= '0;
      col       <= '0;
      maze_oe   <= 1'b0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      path_len  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        st_idle: begin
          if (start) begin
            row      <= '0;
            col      <= '0;
            path_len <= '0;
            maze_oe  <= 1'b1;
            busy     <= 1'b1;
            state    <= st_read;
          end
        end

        st_read: begin
          maze_oe <= 1'b0;
          state   <= st_check;
        end

        st_check, st_emit: begin
          if (state == st_check && cell_in == cell_visited) begin
            out_row   <= row;
            out_col   <= col;
            out_valid <= 1'b1;
            state     <= st_emit;
          end else if (advance) begin
            if (state == st_emit) begin
              path_len  <= path_len + 1'b1;
              out_valid <= 1'b0;
            end
            // The last cell ends the scan; the pointer is left parked there rather than wrapping.
            if (last_cell) begin
              done  <= 1'b1;
              state <= st_finish;
            end else begin
              {row, col} <= {row, col} + 1'b1;
              maze_oe    <= 1'b1;
              state      <= st_read;
            end
          end
        end

        st_finish: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= st_idle;
        end

        default: begin
          maze_oe   <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          state     <= st_idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maze_path_reader.sv
// Directed bench for maze_path_reader on a 4x4 maze with a synchronous memory model.
module tb_maze_path_reader;

  localparam int W = 2;
  localparam int CELLS = 1 << (2 * W);

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   row, col;
  logic           maze_oe;
  logic [1:0]     cell_in;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_row, out_col;
  logic [2*W:0]   path_len;
  logic           busy;
  logic           done;

  logic [1:0] mem [CELLS];

  int errors = 0;
  int checks = 0;

  int done_cyc, done_cnt, oe_cnt, first_oe, last_oe;
  int addr_bad, stall_bad, xcnt;
  bit oe_even, post_busy, timed_out;
  logic [2*W:0] pl_start;
  logic [W-1:0] xr [4];
  logic [W-1:0] xc [4];

  maze_path_reader #(.maze_width(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .row       (row),
    .col       (col),
    .maze_oe   (maze_oe),
    .cell_in   (cell_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_col   (out_col),
    .path_len  (path_len),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (maze_oe) cell_in <= mem[{row, col}];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < CELLS; i++) mem[i] = 2'd0;
  endtask

  // Pulses start, then watches the scan cycle by cycle (cycle 1 = first READ) until
  // three cycles past done. stall = cycles out_ready is held low at each EMIT.
  task automatic scan(input int stall, input bit inject);
    int n;
    int sc;
    bit hold;
    logic [W-1:0] hr, hc;
    done_cyc = -1; done_cnt = 0; oe_cnt = 0; first_oe = -1; last_oe = -1;
    addr_bad = 0; stall_bad = 0; xcnt = 0;
    oe_even = 0; post_busy = 0; timed_out = 0;
    sc = 0; hold = 0; hr = '0; hc = '0;
    @(negedge clk);
    start = 1'b1;
    out_ready = (stall == 0);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    pl_start = path_len;
    while (done_cyc < 0 || n < done_cyc + 4) begin
      if (n > 400) begin
        timed_out = 1;
        break;
      end
      if (maze_oe) begin
        if (first_oe < 0) first_oe = n;
        last_oe = n;
        if (n % 2 == 0) oe_even = 1;
        if ({row, col} != oe_cnt[2*W-1:0]) addr_bad++;
        oe_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = n;
      end
      if (done_cyc >= 0 && n > done_cyc && busy) post_busy = 1;
      if (out_valid) begin
        if (hold && (out_row != hr || out_col != hc || maze_oe)) stall_bad++;
        hr = out_row;
        hc = out_col;
        if (sc < stall) begin
          out_ready = 1'b0;
          sc++;
          hold = 1;
        end else begin
          out_ready = 1'b1;
          if (xcnt < 4) begin
            xr[xcnt] = out_row;
            xc[xcnt] = out_col;
          end
          xcnt++;
          sc = 0;
          hold = 0;
        end
      end
      start = inject && (maze_oe || out_valid || done);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("scan_timeout", 32'(timed_out), 32'd0);
  endtask

  initial begin
    int waited;
    start = 1'b0;
    out_ready = 1'b1;
    cell_in = 2'd0;
    rst_n = 1'b0;
    clear_mem();
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_path_len", 32'(path_len), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;

    // All cells free.
    scan(0, 0);
    check("t1_path_len_at_start", 32'(pl_start), 32'd0);
    check("t1_first_oe", 32'(first_oe), 32'd1);
    check("t1_last_oe", 32'(last_oe), 32'd31);
    check("t1_oe_count", 32'(oe_cnt), 32'd16);
    check("t1_oe_even", 32'(oe_even), 32'd0);
    check("t1_addr_order", 32'(addr_bad), 32'd0);
    check("t1_done_cycle", 32'(done_cyc), 32'd33);
    check("t1_done_count", 32'(done_cnt), 32'd1);
    check("t1_path_len", 32'(path_len), 32'd0);
    check("t1_transfers", 32'(xcnt), 32'd0);

    // Only (1,2) visited; a wall and a reserved code elsewhere.
    clear_mem();
    mem[6] = 2'd2;
    mem[0] = 2'd1;
    mem[9] = 2'd3;
    scan(0, 0);
    check("t2_done_cycle", 32'(done_cyc), 32'd34);
    check("t2_transfers", 32'(xcnt), 32'd1);
    check("t2_out_row", 32'(xr[0]), 32'd1);
    check("t2_out_col", 32'(xc[0]), 32'd2);
    check("t2_path_len", 32'(path_len), 32'd1);
    check("t2_out_row_held", 32'(out_row), 32'd1);
    check("t2_out_col_held", 32'(out_col), 32'd2);

    // Back-pressure: 5 stall cycles at each of (0,1) and (2,3).
    clear_mem();
    mem[1] = 2'd2;
    mem[11] = 2'd2;
    scan(5, 0);
    check("t3_done_cycle", 32'(done_cyc), 32'd45);
    check("t3_transfers", 32'(xcnt), 32'd2);
    check("t3_x0_row", 32'(xr[0]), 32'd0);
    check("t3_x0_col", 32'(xc[0]), 32'd1);
    check("t3_x1_row", 32'(xr[1]), 32'd2);
    check("t3_x1_col", 32'(xc[1]), 32'd3);
    check("t3_stall_stable", 32'(stall_bad), 32'd0);
    check("t3_path_len", 32'(path_len), 32'd2);

    // Previous result stays visible in IDLE until the next start.
    repeat (3) @(negedge clk);
    check("t4_path_len_kept", 32'(path_len), 32'd2);

    // Only the last cell visited; start pulsed in READ, EMIT and FINISH.
    clear_mem();
    mem[15] = 2'd2;
    scan(0, 1);
    check("t4_path_len_at_start", 32'(pl_start), 32'd0);
    check("t4_done_cycle", 32'(done_cyc), 32'd34);
    check("t4_done_count", 32'(done_cnt), 32'd1);
    check("t4_transfers", 32'(xcnt), 32'd1);
    check("t4_out_row", 32'(xr[0]), 32'd3);
    check("t4_out_col", 32'(xc[0]), 32'd3);
    check("t4_addr_order", 32'(addr_bad), 32'd0);
    check("t4_oe_count", 32'(oe_cnt), 32'd16);
    check("t4_busy_after_done", 32'(post_busy), 32'd0);
    check("t4_row_parked", 32'(row), 32'd3);
    check("t4_col_parked", 32'(col), 32'd3);
    check("t4_path_len", 32'(path_len), 32'd1);

    // Reset while stalled in EMIT.
    clear_mem();
    mem[1] = 2'd2;
    mem[11] = 2'd2;
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (!out_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("t5_reached_emit", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_row", 32'(row), 32'd0);
    check("t5_rst_col", 32'(col), 32'd0);
    check("t5_rst_oe", 32'(maze_oe), 32'd0);
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_out_row", 32'(out_row), 32'd0);
    check("t5_rst_out_col", 32'(out_col), 32'd0);
    check("t5_rst_path_len", 32'(path_len), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_no_done_after_rst", 32'(done), 32'd0);
    scan(0, 0);
    check("t5_first_oe", 32'(first_oe), 32'd1);
    check("t5_done_cycle", 32'(done_cyc), 32'd35);
    check("t5_transfers", 32'(xcnt), 32'd2);
    check("t5_x0_col", 32'(xc[0]), 32'd1);
    check("t5_x1_row", 32'(xr[1]), 32'd2);
    check("t5_path_len", 32'(path_len), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
